// File: rtl/neurocam_pkg.sv
// neurocam_pkg: opcodes, decoder FSM states and response codes
// shared by the neurocam command decoder files.
package neurocam_pkg;

    typedef enum logic [1:0] {
        OP_NOP    = 2'd0,
        OP_WRITE  = 2'd1,
        OP_SEARCH = 2'd2,
        OP_READ   = 2'd3
    } op_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARG2,
        ST_ISSUE,
        ST_WAIT,
        ST_RESP
    } state_t;

    localparam logic [7:0] RESP_WR_ACK  = 8'hA5;
    localparam logic [7:0] RESP_TIMEOUT = 8'hEE;
    localparam logic [7:0] RESP_PARITY  = 8'hEF;

    function automatic logic [7:0] search_resp(
        input logic       hit,
        input logic [3:0] addr
    );
        return hit ? {1'b1, 3'b000, addr} : 8'h00;
    endfunction

endpackage

// File: rtl/neurocam_strobe_sync.sv
// neurocam_strobe_sync: brings the asynchronous host strobe into clk
// through two flops and emits a one-cycle pulse on its rising edge.
module neurocam_strobe_sync
    import neurocam_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic strobe_i,
    output logic stb_o
);

    logic [2:0] sync_q;
    logic [2:0] sync_d;

    // Shift the raw strobe into the synchroniser / edge-history chain.
    always_comb begin
        sync_d = {sync_q[1:0], strobe_i};
    end

    // Synchroniser and edge-history register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync_q <= '0;
        else        sync_q <= sync_d;
    end

    assign stb_o = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/neurocam_cmd_decoder.sv
// neurocam_cmd_decoder: strobe-framed WRITE/READ/SEARCH command decoder
// driving CAM request pulses; optional NEUROCAM_PARITY_EN byte parity check.
module neurocam_cmd_decoder
    import neurocam_pkg::*;
#(
    parameter int ADDR_W      = 4,
    parameter int DATA_W      = 8,
    parameter int TIMEOUT_CYC = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic              cmd_strobe_i,
    input  logic [1:0]        cmd_op_i,
    input  logic              cmd_par_i,
    input  logic [DATA_W-1:0] cmd_byte_i,
    output logic              cam_we_o,
    output logic              cam_re_o,
    output logic              cam_search_o,
    output logic [ADDR_W-1:0] cam_addr_o,
    output logic [DATA_W-1:0] cam_wdata_o,
    input  logic              cam_ack_i,
    input  logic              cam_hit_i,
    input  logic [DATA_W-1:0] cam_rdata_i,
    output logic [DATA_W-1:0] resp_byte_o,
    output logic              resp_valid_o,
    output logic              busy_o
);

    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    logic              stb_raw;
    logic              stb;
    logic              par_err;
    state_t            state_q, state_d;
    op_t               op_q, op_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] resp_byte_q, resp_byte_d;
    logic              resp_valid_q, resp_valid_d;
    logic [7:0]        drop_q, drop_d;

    neurocam_strobe_sync u_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .strobe_i (cmd_strobe_i),
        .stb_o    (stb_raw)
    );

    assign stb = stb_raw & ena;

`ifdef NEUROCAM_PARITY_EN
    assign par_err = ~^{cmd_op_i, cmd_byte_i, cmd_par_i};
`else
    logic par_unused;
    assign par_err    = 1'b0;
    assign par_unused = cmd_par_i;
`endif

    // Next-state, argument capture, timeout and response selection.
    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        cnt_d        = cnt_q;
        resp_byte_d  = resp_byte_q;
        resp_valid_d = resp_valid_q;
        drop_d       = drop_q;
        unique case (state_q)
            ST_IDLE, ST_RESP: begin
                state_d = ST_IDLE;
                if (stb) begin
                    resp_valid_d = 1'b0;
                    op_d         = op_t'(cmd_op_i);
                    if (par_err) begin
                        resp_byte_d  = RESP_PARITY;
                        resp_valid_d = 1'b1;
                    end else begin
                        unique case (op_t'(cmd_op_i))
                            OP_NOP:    state_d = ST_IDLE;
                            OP_WRITE: begin
                                addr_d  = cmd_byte_i[ADDR_W-1:0];
                                state_d = ST_ARG2;
                            end
                            OP_SEARCH: begin
                                wdata_d = cmd_byte_i;
                                state_d = ST_ISSUE;
                            end
                            OP_READ: begin
                                addr_d  = cmd_byte_i[ADDR_W-1:0];
                                state_d = ST_ISSUE;
                            end
                        endcase
                    end
                end
            end
            ST_ARG2: begin
                if (stb) begin
                    if (par_err) begin
                        resp_byte_d  = RESP_PARITY;
                        resp_valid_d = 1'b1;
                        state_d      = ST_IDLE;
                    end else begin
                        wdata_d = cmd_byte_i;
                        state_d = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                cnt_d   = '0;
                state_d = ST_WAIT;
                if (stb) drop_d = drop_q + 8'd1;
            end
            ST_WAIT: begin
                if (stb) drop_d = drop_q + 8'd1;
                if (cam_ack_i) begin
                    unique case (op_q)
                        OP_SEARCH: resp_byte_d = search_resp(cam_hit_i, cam_rdata_i[3:0]);
                        OP_READ:   resp_byte_d = cam_rdata_i;
                        default:   resp_byte_d = RESP_WR_ACK;
                    endcase
                    resp_valid_d = 1'b1;
                    state_d      = ST_RESP;
                end else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
                    resp_byte_d  = RESP_TIMEOUT;
                    resp_valid_d = 1'b1;
                    state_d      = ST_RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Decoder state and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            op_q         <= OP_NOP;
            addr_q       <= '0;
            wdata_q      <= '0;
            cnt_q        <= '0;
            resp_byte_q  <= '0;
            resp_valid_q <= 1'b0;
            drop_q       <= '0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            cnt_q        <= cnt_d;
            resp_byte_q  <= resp_byte_d;
            resp_valid_q <= resp_valid_d;
            drop_q       <= drop_d;
        end
    end

    assign cam_we_o     = (state_q == ST_ISSUE) && (op_q == OP_WRITE);
    assign cam_re_o     = (state_q == ST_ISSUE) && (op_q == OP_READ);
    assign cam_search_o = (state_q == ST_ISSUE) && (op_q == OP_SEARCH);
    assign cam_addr_o   = addr_q;
    assign cam_wdata_o  = wdata_q;
    assign resp_byte_o  = resp_byte_q;
    assign resp_valid_o = resp_valid_q;
    assign busy_o       = (state_q == ST_ARG2) || (state_q == ST_ISSUE)
                       || (state_q == ST_WAIT);

endmodule

// File: tb/tb_neurocam_cmd_decoder.sv
// tb_neurocam_cmd_decoder: table vectors, corner sequences and random
// commands against a CAM model and a behavioural response reference.
module tb_neurocam_cmd_decoder;
    import neurocam_pkg::*;

    localparam int  TO    = 15;
    localparam time CLK_P = 10;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b1;
    logic       cmd_strobe_i = 1'b0;
    logic [1:0] cmd_op_i = 2'd0;
    logic       cmd_par_i = 1'b0;
    logic [7:0] cmd_byte_i = 8'd0;
    logic       cam_we_o, cam_re_o, cam_search_o;
    logic [3:0] cam_addr_o;
    logic [7:0] cam_wdata_o;
    logic       cam_ack_i, cam_hit_i;
    logic [7:0] cam_rdata_i;
    logic [7:0] resp_byte_o;
    logic       resp_valid_o, busy_o;

    neurocam_cmd_decoder #(.ADDR_W(4), .DATA_W(8), .TIMEOUT_CYC(TO)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ena          (ena),
        .cmd_strobe_i (cmd_strobe_i),
        .cmd_op_i     (cmd_op_i),
        .cmd_par_i    (cmd_par_i),
        .cmd_byte_i   (cmd_byte_i),
        .cam_we_o     (cam_we_o),
        .cam_re_o     (cam_re_o),
        .cam_search_o (cam_search_o),
        .cam_addr_o   (cam_addr_o),
        .cam_wdata_o  (cam_wdata_o),
        .cam_ack_i    (cam_ack_i),
        .cam_hit_i    (cam_hit_i),
        .cam_rdata_i  (cam_rdata_i),
        .resp_byte_o  (resp_byte_o),
        .resp_valid_o (resp_valid_o),
        .busy_o       (busy_o)
    );

    always #(CLK_P / 2) clk = ~clk;

    int checks = 0;
    int errors = 0;

    // CAM model: acks cam_lat cycles after a pulse, first-match search.
    int         cam_lat = 2;
    logic       cam_ack_en = 1'b1;
    int         we_n = 0, re_n = 0, se_n = 0;
    logic       multi = 1'b0;
    logic [7:0] cam_mem [16];
    logic [3:0] p_addr;
    logic [7:0] p_wdata;
    logic [1:0] pend;
    int         cd = 0;
    time        t_pulse, t_resp;

    initial begin
        cam_ack_i = 1'b0;
        cam_hit_i = 1'b0;
        cam_rdata_i = 8'd0;
        for (int i = 0; i < 16; i++) cam_mem[i] = 8'd0;
        forever begin
            @(negedge clk);
            cam_ack_i = 1'b0;
            cam_hit_i = 1'b0;
            cam_rdata_i = 8'd0;
            if (cd > 0) begin
                cd--;
                if (cd == 0 && cam_ack_en) begin
                    cam_ack_i = 1'b1;
                    if (pend == OP_READ) cam_rdata_i = cam_mem[p_addr];
                    else if (pend == OP_SEARCH)
                        for (int i = 15; i >= 0; i--)
                            if (cam_mem[i] == p_wdata) begin
                                cam_hit_i = 1'b1;
                                cam_rdata_i = 8'(i);
                            end
                end
            end
            if (cam_we_o || cam_re_o || cam_search_o) begin
                if ($countones({cam_we_o, cam_re_o, cam_search_o}) > 1) multi = 1'b1;
                p_addr = cam_addr_o;
                p_wdata = cam_wdata_o;
                t_pulse = $time;
                cd = cam_lat;
                if (cam_we_o) begin
                    we_n++;
                    pend = OP_WRITE;
                    cam_mem[cam_addr_o] = cam_wdata_o;
                end else if (cam_re_o) begin
                    re_n++;
                    pend = OP_READ;
                end else begin
                    se_n++;
                    pend = OP_SEARCH;
                end
            end
        end
    end

    // Behavioural reference: memory as the host sees it.
    logic [7:0] ref_mem [16];

    function automatic logic [7:0] ref_resp(input logic [1:0] op, input logic [7:0] a);
        if (op == OP_WRITE) return 8'hA5;
        if (op == OP_READ) return ref_mem[a[3:0]];
        for (int i = 0; i < 16; i++)
            if (ref_mem[i] == a) return 8'h80 + 8'(i);
        return 8'h00;
    endfunction

    function automatic int pcode(input logic [1:0] op);
        if (op == OP_WRITE) return 100;
        if (op == OP_READ) return 10;
        if (op == OP_SEARCH) return 1;
        return 0;
    endfunction

    function automatic logic odd_par(input logic [1:0] op, input logic [7:0] b);
        return ~(^{op, b});
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
        end
    endtask

    int w0, r0, s0;
    task automatic snap();
        w0 = we_n; r0 = re_n; s0 = se_n;
    endtask
    function automatic int pdelta();
        return (we_n - w0) * 100 + (re_n - r0) * 10 + (se_n - s0);
    endfunction

    task automatic send_byte(input logic [1:0] op, input logic [7:0] b, input logic bad);
        cmd_op_i = op;
        cmd_byte_i = b;
        cmd_par_i = odd_par(op, b) ^ bad;
        cmd_strobe_i = 1'b1;
        repeat (4) @(posedge clk);
        #1 cmd_strobe_i = 1'b0;
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic wait_resp(output logic ok);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (resp_valid_o) begin
                ok = 1'b1;
                t_resp = $time;
                break;
            end
        end
    endtask

    task automatic run_cmd(input logic [1:0] op, input logic [7:0] b1, input logic [7:0] b2,
                           input logic bad2, output logic [7:0] r, output logic ok);
        send_byte(op, b1, 1'b0);
        if (op == OP_WRITE) begin
            chk("busy_in_arg2", int'(busy_o), 1);
            send_byte(op, b2, bad2);
        end
        wait_resp(ok);
        r = resp_byte_o;
    endtask

    typedef struct {
        logic [1:0] op;
        logic [7:0] b1;
        logic [7:0] b2;
        int         lat;
        logic [7:0] resp;
        logic [3:0] addr;
        logic [7:0] wdata;
    } vec_t;

    vec_t vt [7];

    initial begin
        logic [7:0] r, a, d;
        logic [1:0] op;
        logic       ok;

        for (int i = 0; i < 16; i++) ref_mem[i] = 8'd0;
        vt[0] = '{OP_WRITE,  8'h03, 8'h5C, 2, 8'hA5, 4'h3, 8'h5C};
        vt[1] = '{OP_READ,   8'h03, 8'h00, 1, 8'h5C, 4'h3, 8'h00};
        vt[2] = '{OP_SEARCH, 8'h5C, 8'h00, 3, 8'h83, 4'h0, 8'h5C};
        vt[3] = '{OP_SEARCH, 8'h11, 8'h00, 2, 8'h00, 4'h0, 8'h11};
        vt[4] = '{OP_WRITE,  8'hF7, 8'h11, 4, 8'hA5, 4'h7, 8'h11};
        vt[5] = '{OP_READ,   8'h27, 8'h00, 2, 8'h11, 4'h7, 8'h00};
        vt[6] = '{OP_SEARCH, 8'h11, 8'h00, 1, 8'h87, 4'h0, 8'h11};

        repeat (3) @(negedge clk);
        chk("reset_outputs", int'({resp_byte_o, resp_valid_o, busy_o,
                                   cam_we_o, cam_re_o, cam_search_o}), 0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        for (int i = 0; i < 7; i++) begin
            cam_lat = vt[i].lat;
            snap();
            run_cmd(vt[i].op, vt[i].b1, vt[i].b2, 1'b0, r, ok);
            chk($sformatf("vec%0d_valid", i), int'(ok), 1);
            chk($sformatf("vec%0d_resp", i), int'(r), int'(vt[i].resp));
            chk($sformatf("vec%0d_busy", i), int'(busy_o), 0);
            chk($sformatf("vec%0d_pulses", i), pdelta(), pcode(vt[i].op));
            if (vt[i].op != OP_SEARCH)
                chk($sformatf("vec%0d_addr", i), int'(p_addr), int'(vt[i].addr));
            if (vt[i].op != OP_READ)
                chk($sformatf("vec%0d_wdata", i), int'(p_wdata), int'(vt[i].wdata));
            if (vt[i].op == OP_WRITE) ref_mem[vt[i].b1[3:0]] = vt[i].b2;
        end

        // Timeout: the pulse is seen in the ISSUE cycle; WAIT then runs TO cycles.
        cam_ack_en = 1'b0;
        snap();
        run_cmd(OP_SEARCH, 8'h42, 8'h00, 1'b0, r, ok);
        chk("timeout_valid", int'(ok), 1);
        chk("timeout_resp", int'(r), 'hEE);
        chk("timeout_latency", int'((t_resp - t_pulse) / CLK_P), TO + 1);

        // A byte strobed while waiting on the CAM is discarded.
        snap();
        send_byte(OP_SEARCH, 8'h42, 1'b0);
        send_byte(OP_READ, 8'h03, 1'b0);
        wait_resp(ok);
        chk("drop_resp", int'(resp_byte_o), 'hEE);
        chk("drop_pulses", pdelta(), 1);
        repeat (20) @(negedge clk);
        chk("drop_no_read", pdelta(), 1);
        cam_ack_en = 1'b1;

        // Reset between WRITE address and data bytes.
        cam_lat = 2;
        snap();
        send_byte(OP_WRITE, 8'h03, 1'b0);
        chk("rst_busy_before", int'(busy_o), 1);
        #2 rst_n = 1'b0;
        #3;
        chk("rst_mid_outputs", int'({resp_byte_o, resp_valid_o, busy_o}), 0);
        #12 rst_n = 1'b1;
        repeat (20) @(negedge clk);
        chk("rst_no_write", pdelta(), 0);
        run_cmd(OP_READ, 8'h03, 8'h00, 1'b0, r, ok);
        chk("rst_read_resp", int'(r), 'h5C);

        // ena low: strobes ignored, response held.
        ena = 1'b0;
        snap();
        send_byte(OP_WRITE, 8'h05, 1'b0);
        send_byte(OP_WRITE, 8'h77, 1'b0);
        repeat (10) @(negedge clk);
        chk("ena_busy", int'(busy_o), 0);
        chk("ena_pulses", pdelta(), 0);
        chk("ena_resp_held", int'({resp_valid_o, resp_byte_o}), 'h15C);
        ena = 1'b1;

        // Bad parity on the WRITE data byte.
        snap();
        run_cmd(OP_WRITE, 8'h0A, 8'h99, 1'b1, r, ok);
`ifdef NEUROCAM_PARITY_EN
        chk("parity_resp", int'(r), 'hEF);
        chk("parity_pulses", pdelta(), 0);
`else
        chk("parity_resp", int'(r), 'hA5);
        chk("parity_pulses", pdelta(), 100);
        ref_mem[10] = 8'h99;
`endif

        // NOP: no CAM activity, not busy.
        snap();
        send_byte(OP_NOP, 8'h3C, 1'b0);
        repeat (10) @(negedge clk);
        chk("nop_busy", int'(busy_o), 0);
        chk("nop_pulses", pdelta(), 0);

        // Random commands against the reference.
        for (int n = 0; n < 30; n++) begin
            op = 2'($urandom_range(1, 3));
            d = 8'($urandom);
            if (op == OP_SEARCH && $urandom_range(0, 1) == 1)
                a = ref_mem[$urandom_range(0, 15)];
            else
                a = 8'($urandom);
            cam_lat = $urandom_range(1, 4);
            snap();
            run_cmd(op, a, d, 1'b0, r, ok);
            chk($sformatf("rnd%0d_valid", n), int'(ok), 1);
            chk($sformatf("rnd%0d_resp", n), int'(r), int'(ref_resp(op, a)));
            chk($sformatf("rnd%0d_pulses", n), pdelta(), pcode(op));
            if (op == OP_WRITE) begin
                chk($sformatf("rnd%0d_wr", n), int'({p_addr, p_wdata}), int'({a[3:0], d}));
                ref_mem[a[3:0]] = d;
            end
        end

        chk("single_pulse", int'(multi), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1);
    end

endmodule

// File: doc/neurocam_cmd_decoder.md
Name: neurocam_cmd_decoder

Overview:
- Pin-side command responder inside tt_um_neurocam.
- Takes the byte-wide, strobe-framed command stream that a host or bench drives onto the dedicated and bidirectional inputs.
- Decodes WRITE / READ / SEARCH commands, issues single-cycle requests to the CAM core, and returns one response byte with a valid flag on the dedicated outputs.

Parameters:
- ADDR_W, 4, CAM entry address width (16 entries).
- DATA_W, 8, CAM word width; fixed to pin byte width.
- TIMEOUT_CYC, 15, max cycles waiting for the CAM response before an error response is returned.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- ena  in  1  design selected; when low, strobes are ignored.
- cmd_strobe_i  in  1  ui_in[2]; asynchronous host strobe, one byte per rising edge.
- cmd_op_i  in  2  ui_in[1:0]; opcode sampled with the first byte of a command.
- cmd_par_i  in  1  ui_in[3]; odd parity over {op, byte}; used only with the optional feature.
- cmd_byte_i  in  8  uio_in; command byte.
- cam_we_o  out  1  CAM write pulse.
- cam_re_o  out  1  CAM read pulse.
- cam_search_o  out  1  CAM search pulse.
- cam_addr_o  out  ADDR_W  CAM address.
- cam_wdata_o  out  8  write data / search key.
- cam_ack_i  in  1  CAM response valid.
- cam_hit_i  in  1  search hit.
- cam_rdata_i  in  8  read data, or hit address zero-extended for a search.
- resp_byte_o  out  8  uo_out; response byte.
- resp_valid_o  out  1  response-valid level, routed to uio_out[7].
- busy_o  out  1  command in progress, routed to uio_out[6].

Behaviour:
- Reset (async, rst_n low): all outputs 0, FSM to IDLE, synchronisers cleared. Reset mid-command drops the command with no CAM pulse.
- Strobe handling: cmd_strobe_i passes through a 2-FF synchroniser, then rising-edge detect gives stb (1 cycle). cmd_op_i, cmd_byte_i and cmd_par_i are sampled in the cycle stb fires; the host holds them stable across the strobe. stb is ignored when ena=0.
- Opcodes: 0 NOP, 1 WRITE (addr byte, then data byte), 2 SEARCH (key byte), 3 READ (addr byte). Address = byte[ADDR_W-1:0]; upper bits ignored.
- FSM states:
  - IDLE: on stb, NOP stays IDLE with no response. WRITE captures addr and goes to ARG2. SEARCH/READ capture and go to ISSUE.
  - ARG2: next stb captures data and goes to ISSUE. That stb's cmd_op_i is ignored.
  - ISSUE: exactly one of cam_we_o/cam_re_o/cam_search_o high for one cycle with addr/wdata valid; then WAIT.
  - WAIT: on cam_ack_i, go to RESP. If the timeout counter reaches TIMEOUT_CYC first, go to RESP with error.
  - RESP: resp_byte_o is loaded, resp_valid_o=1, return to IDLE.
- Response values:
  - WRITE ack: 0xA5.
  - READ: cam_rdata_i.
  - SEARCH hit: {1'b1, 3'b0, hit addr[3:0]}. SEARCH miss: 0x00.
  - Timeout: 0xEE.
- resp_byte_o / resp_valid_o hold until the next accepted stb, which clears resp_valid_o in the same cycle it starts the new command.
- busy_o is high from the first byte until RESP.
- stb arriving in ISSUE/WAIT is discarded and counted (no effect on state).
- cam_ack_i outside WAIT is ignored.
- Latency for SEARCH/READ: strobe pin edge to resp_valid_o is 3 sync/edge cycles + 1 ISSUE + CAM latency + 1.
- uio_oe is driven 8'hC0 by the top, not by this block.

Optional Feature:
- Macro: NEUROCAM_PARITY_EN.
- Defined: each accepted byte checks odd parity of {cmd_op_i, cmd_byte_i, cmd_par_i}. On mismatch the command is aborted with no CAM pulse, resp_byte_o=0xEF, resp_valid_o=1, and the FSM returns to IDLE.
- Undefined: cmd_par_i is unused and no parity logic is synthesised.

Decomposition:
- Package neurocam_pkg holds:
  - the opcode enum (OP_NOP, OP_WRITE, OP_SEARCH, OP_READ);
  - the FSM state enum;
  - response constants RESP_WR_ACK=8'hA5, RESP_TIMEOUT=8'hEE, RESP_PARITY=8'hEF.
- One sub-module, neurocam_strobe_sync: 2-FF synchroniser plus rising-edge pulse, async active-low reset.

Test Plan:
- WRITE addr 0x03, data 0x5C with a CAM model acking after 2 cycles -> one cam_we_o pulse with addr=3, wdata=0x5C; resp 0xA5 valid; busy_o drops.
- READ addr 0x03 with the model returning 0x5C -> cam_re_o pulse; resp_byte_o=0x5C.
- SEARCH key 0x5C, model hit at addr 3 -> resp 0x83. SEARCH key 0x11 with a miss -> resp 0x00.
- SEARCH with the model never acking -> resp 0xEE exactly TIMEOUT_CYC cycles after leaving ISSUE.
- Assert rst_n low between the WRITE addr and data bytes -> no cam_we_o ever; after release, a READ completes normally. ena=0 strobes produce no activity.
- With NEUROCAM_PARITY_EN, a WRITE with a bad parity bit on the data byte -> no cam_we_o and resp 0xEF; with the macro undefined, the same stimulus -> resp 0xA5.
